// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO definitions.
//   DEF_DWIDTH / DEF_AWIDTH : default data and address widths
//   usedw_next()            : fill-count update from accepted write/read
// Kept separate so a later dual-clock FIFO can reuse the same count rule.
package fifo_pkg;

  localparam int unsigned DEF_DWIDTH = 8;
  localparam int unsigned DEF_AWIDTH = 4;

  // Count moves only when exactly one side is accepted; simultaneous
  // accepted write and read leave the occupancy unchanged.
  function automatic int unsigned usedw_next(input int unsigned usedw,
                                             input logic wr_acc,
                                             input logic rd_acc);
    if (wr_acc && !rd_acc) return usedw + 1;
    if (rd_acc && !wr_acc) return usedw - 1;
    return usedw;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DWIDTH x 2**AWIDTH storage, synchronous write, asynchronous read.
// Ports:
//   clk_i    in   clock (write on posedge)
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data, combinational from raddr_i
// Contents are never cleared; the FIFO top tracks which words are valid.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned AWIDTH = DEF_AWIDTH
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [2**AWIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sc_fifo.sv
// sc_fifo: single-clock FIFO with full/empty, almost flags and fill count.
// Parameters: DWIDTH, AWIDTH (depth 2**AWIDTH), SHOWAHEAD (1 = head word
//   visible on q_o while not empty, 0 = registered read one cycle after
//   rdreq_i), ALMOST_FULL, ALMOST_EMPTY thresholds.
// Ports:
//   clk_i, srst_i          clock, synchronous active-high reset
//   data_i, wrreq_i        write data / request (dropped when full)
//   rdreq_i                read request (ignored when empty)
//   q_o                    read data
//   empty_o, full_o        occupancy flags
//   almost_empty_o         usedw_o <  ALMOST_EMPTY
//   almost_full_o          usedw_o >= ALMOST_FULL
//   usedw_o                words stored, 0..2**AWIDTH
// Optional: define SC_FIFO_ERR_FLAGS_EN to add sticky ovf_o / udf_o,
//   set by a write while full / read while empty, cleared only by srst_i.
module sc_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH       = DEF_DWIDTH,
  parameter int unsigned AWIDTH       = DEF_AWIDTH,
  parameter bit          SHOWAHEAD    = 1'b0,
  parameter int unsigned ALMOST_FULL  = 12,
  parameter int unsigned ALMOST_EMPTY = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic [AWIDTH:0]   usedw_o
`ifdef SC_FIFO_ERR_FLAGS_EN
  ,
  output logic              ovf_o,
  output logic              udf_o
`endif
);

  localparam int unsigned DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W = DEPTH[AWIDTH:0];
  localparam logic [AWIDTH:0] AF_TH   = ALMOST_FULL[AWIDTH:0];
  localparam logic [AWIDTH:0] AE_TH   = ALMOST_EMPTY[AWIDTH:0];

  if (ALMOST_FULL > DEPTH) begin : g_chk_af
    $error("sc_fifo: ALMOST_FULL exceeds FIFO depth");
  end
  if (ALMOST_EMPTY > DEPTH) begin : g_chk_ae
    $error("sc_fifo: ALMOST_EMPTY exceeds FIFO depth");
  end

  logic [AWIDTH-1:0] wrptr_q, rdptr_q;
  logic [AWIDTH:0]   usedw_q, usedw_d;
  logic              empty_q, full_q, aempty_q, afull_q;
  logic              wr_acc, rd_acc;
  logic [DWIDTH-1:0] rdata;

  // Acceptance is judged on the registered flags, so a full FIFO with
  // wr&rd drops the write and an empty FIFO with wr&rd ignores the read.
  assign wr_acc  = wrreq_i & ~full_q;
  assign rd_acc  = rdreq_i & ~empty_q;
  assign usedw_d = (AWIDTH+1)'(usedw_next(32'(usedw_q), wr_acc, rd_acc));

  fifo_mem #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc & ~srst_i),
    .waddr_i (wrptr_q),
    .wdata_i (data_i),
    .raddr_i (rdptr_q),
    .rdata_o (rdata)
  );

  // Flags are computed from the next count so they change on the same
  // edge as usedw_o.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wrptr_q  <= '0;
      rdptr_q  <= '0;
      usedw_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
    end else begin
      if (wr_acc) wrptr_q <= wrptr_q + AWIDTH'(1);
      if (rd_acc) rdptr_q <= rdptr_q + AWIDTH'(1);
      usedw_q  <= usedw_d;
      empty_q  <= (usedw_d == '0);
      full_q   <= (usedw_d == DEPTH_W);
      aempty_q <= (usedw_d < AE_TH);
      afull_q  <= (usedw_d >= AF_TH);
    end
  end

  if (SHOWAHEAD) begin : g_showahead
    assign q_o = empty_q ? '0 : rdata;
  end else begin : g_normal
    logic [DWIDTH-1:0] q_q;
    always_ff @(posedge clk_i) begin
      if (srst_i)      q_q <= '0;
      else if (rd_acc) q_q <= rdata;
    end
    assign q_o = q_q;
  end

`ifdef SC_FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wrreq_i & full_q)  ovf_q <= 1'b1;
      if (rdreq_i & empty_q) udf_q <= 1'b1;
    end
  end
  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`endif

  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_empty_o = aempty_q;
  assign almost_full_o  = afull_q;
  assign usedw_o        = usedw_q;

endmodule

// File: tb/tb_sc_fifo.sv
// tb_sc_fifo: drives a normal-mode and a show-ahead sc_fifo with the same
// directed stimulus and compares both against a queue-based model every
// cycle, plus literal expectations at key points of the sequence.
module tb_sc_fifo;

  logic       clk = 1'b0;
  logic       srst = 1'b0;
  logic [7:0] data = '0;
  logic       wrreq = 1'b0;
  logic       rdreq = 1'b0;

  logic [7:0] n_q, s_q;
  logic       n_empty, n_full, n_ae, n_af, s_empty, s_full, s_ae, s_af;
  logic [4:0] n_usedw, s_usedw;
  logic       n_ovf, n_udf, s_ovf, s_udf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sc_fifo #(.DWIDTH(8), .AWIDTH(4), .SHOWAHEAD(1'b0), .ALMOST_FULL(12), .ALMOST_EMPTY(4)) u_norm (
    .clk_i(clk), .srst_i(srst), .data_i(data), .wrreq_i(wrreq), .rdreq_i(rdreq),
    .q_o(n_q), .empty_o(n_empty), .full_o(n_full), .almost_empty_o(n_ae),
    .almost_full_o(n_af), .usedw_o(n_usedw)
`ifdef SC_FIFO_ERR_FLAGS_EN
    , .ovf_o(n_ovf), .udf_o(n_udf)
`endif
  );

  sc_fifo #(.DWIDTH(8), .AWIDTH(4), .SHOWAHEAD(1'b1), .ALMOST_FULL(12), .ALMOST_EMPTY(4)) u_show (
    .clk_i(clk), .srst_i(srst), .data_i(data), .wrreq_i(wrreq), .rdreq_i(rdreq),
    .q_o(s_q), .empty_o(s_empty), .full_o(s_full), .almost_empty_o(s_ae),
    .almost_full_o(s_af), .usedw_o(s_usedw)
`ifdef SC_FIFO_ERR_FLAGS_EN
    , .ovf_o(s_ovf), .udf_o(s_udf)
`endif
  );

`ifndef SC_FIFO_ERR_FLAGS_EN
  assign n_ovf = 1'b0;
  assign n_udf = 1'b0;
  assign s_ovf = 1'b0;
  assign s_udf = 1'b0;
`endif

  // Behavioural model: a queue of stored words plus the last word read.
  logic [7:0] m_fifo[$];
  logic [7:0] m_qn  = '0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    if (srst) begin
      m_fifo.delete();
      m_qn   = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      chk_en = 1'b1;
    end else begin
      bit was_full, was_empty;
      was_full  = (m_fifo.size() == 16);
      was_empty = (m_fifo.size() == 0);
      if (wrreq && was_full)  m_ovf = 1'b1;
      if (rdreq && was_empty) m_udf = 1'b1;
      if (rdreq && !was_empty) m_qn = m_fifo.pop_front();
      if (wrreq && !was_full)  m_fifo.push_back(data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && !srst) begin
      int sz;
      logic [7:0] head;
      sz   = m_fifo.size();
      head = (sz != 0) ? m_fifo[0] : 8'h00;
      check("n_usedw", 32'(n_usedw), 32'(sz));
      check("n_empty", 32'(n_empty), 32'(sz == 0));
      check("n_full",  32'(n_full),  32'(sz == 16));
      check("n_ae",    32'(n_ae),    32'(sz < 4));
      check("n_af",    32'(n_af),    32'(sz >= 12));
      check("n_q",     32'(n_q),     32'(m_qn));
      check("s_usedw", 32'(s_usedw), 32'(sz));
      check("s_empty", 32'(s_empty), 32'(sz == 0));
      check("s_full",  32'(s_full),  32'(sz == 16));
      check("s_ae",    32'(s_ae),    32'(sz < 4));
      check("s_af",    32'(s_af),    32'(sz >= 12));
      check("s_q",     32'(s_q),     32'(head));
`ifdef SC_FIFO_ERR_FLAGS_EN
      check("n_ovf", 32'(n_ovf), 32'(m_ovf));
      check("n_udf", 32'(n_udf), 32'(m_udf));
      check("s_ovf", 32'(s_ovf), 32'(m_ovf));
      check("s_udf", 32'(s_udf), 32'(m_udf));
`endif
    end
  end

  // One clock of stimulus; returns on the following falling edge.
  task automatic step(input logic wr, input logic rd, input logic [7:0] d, input logic rst = 1'b0);
    wrreq = wr;
    rdreq = rd;
    data  = d;
    srst  = rst;
    $display("txn t=%0t srst=%b wr=%b rd=%b data=%02h", $time, rst, wr, rd, d);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    // 1: reset then idle
    step(0, 0, 8'h00, 1'b1);
    step(0, 0, 8'h00, 1'b1);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    check("lit_rst_empty", 32'(n_empty), 32'd1);
    check("lit_rst_usedw", 32'(s_usedw), 32'd0);
    check("lit_rst_full",  32'(n_full),  32'd0);
    check("lit_rst_nq",    32'(n_q),     32'd0);
    check("lit_rst_sq",    32'(s_q),     32'd0);

    // 2: fill to full, then one dropped write
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'(i));
      if (i == 0)  check("lit_show_first", 32'(s_q), 32'h00);
      if (i == 10) check("lit_af_11", 32'(n_af), 32'd0);
      if (i == 11) check("lit_af_12", 32'(n_af), 32'd1);
    end
    check("lit_full",       32'(n_full),  32'd1);
    check("lit_full_usedw", 32'(n_usedw), 32'd16);
    step(1, 0, 8'hAA);
    check("lit_drop_usedw", 32'(s_usedw), 32'd16);
`ifdef SC_FIFO_ERR_FLAGS_EN
    check("lit_ovf", 32'(n_ovf), 32'd1);
`endif

    // 3: drain 16, then one read while empty
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'h00);
      check("lit_rd_nq", 32'(n_q), 32'(i));
      if (i == 12) check("lit_ae_3", 32'(n_ae), 32'd1);
    end
    check("lit_empty", 32'(n_empty), 32'd1);
    step(0, 1, 8'h00);
    check("lit_udf_nq", 32'(n_q), 32'h0F);
`ifdef SC_FIFO_ERR_FLAGS_EN
    check("lit_udf", 32'(s_udf), 32'd1);
`endif

    // 4: steady wr&rd at usedw=5, pointers wrap
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h20 + i));
    for (int i = 0; i < 40; i++) step(1, 1, 8'(8'h40 + i));
    check("lit_steady_usedw", 32'(n_usedw), 32'd5);
    check("lit_steady_nq",    32'(n_q),     32'h62);
    check("lit_steady_sq",    32'(s_q),     32'h63);

    // 5: full + wr&rd, then empty + wr&rd
    for (int i = 0; i < 11; i++) step(1, 0, 8'(8'h80 + i));
    check("lit_full2", 32'(s_full), 32'd1);
    step(1, 1, 8'hAA);
    check("lit_fullwr_usedw", 32'(n_usedw), 32'd15);
    for (int i = 0; i < 15; i++) step(0, 1, 8'h00);
    check("lit_last_nq", 32'(n_q), 32'h8A);
    step(1, 1, 8'h55);
    check("lit_emptywr_usedw", 32'(n_usedw), 32'd1);
    check("lit_emptywr_sq",    32'(s_q),     32'h55);
    step(0, 1, 8'h00);
    check("lit_emptywr_nq", 32'(n_q), 32'h55);

    // 6: reset mid-traffic with requests in the reset cycle
    for (int i = 0; i < 9; i++) step(1, 0, 8'(8'hC0 + i));
    check("lit_pre_rst", 32'(n_usedw), 32'd9);
    step(1, 1, 8'hEE, 1'b1);
    check("lit_mid_rst_empty", 32'(n_empty), 32'd1);
    check("lit_mid_rst_usedw", 32'(s_usedw), 32'd0);
    check("lit_mid_rst_ae",    32'(n_ae),    32'd1);
    check("lit_mid_rst_nq",    32'(n_q),     32'd0);
`ifdef SC_FIFO_ERR_FLAGS_EN
    check("lit_mid_rst_ovf", 32'(n_ovf), 32'd0);
    check("lit_mid_rst_udf", 32'(n_udf), 32'd0);
`endif
    step(1, 0, 8'h12);
    step(0, 1, 8'h00);
    check("lit_post_rst_nq", 32'(n_q), 32'h12);
    step(0, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
